// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic [InstBus-1:0]     NopInst   = 32'h0000_0000;
    localparam logic                   RstEnable = 1'b1;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_pair_t;

    function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_skid_buf.sv
// One-entry {pc, inst} holding register; clear wins over load.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  fetch_pair_t data_i,
    output fetch_pair_t data_o,
    output logic        valid_o
);

    fetch_pair_t data_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear_i || unload_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, ibus handshake and IF/ID register with stall,
// redirect and discard of stale in-flight fetches.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [InstAddrBus-1:0] redirect_pc_i,
    output logic                   ibus_req_o,
    output logic [InstAddrBus-1:0] ibus_addr_o,
    input  logic                   ibus_ack_i,
    input  logic [InstBus-1:0]     ibus_rdata_i,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o,
    output logic                   id_valid_o
);

    if_state_e              state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   req_q, req_d;
    logic [InstAddrBus-1:0] addr_q, addr_d;
    logic [InstAddrBus-1:0] id_pc_q, id_pc_d;
    logic [InstBus-1:0]     id_inst_q, id_inst_d;
    logic                   id_valid_q, id_valid_d;

    logic                   ack_c;
    logic                   skid_load, skid_unload, skid_clear, skid_valid;
    fetch_pair_t            skid_in, skid_out;
    logic [InstAddrBus-1:0] pc_inc, redirect_target;

    // An ack only counts while a request is actually outstanding.
    assign ack_c           = ibus_ack_i && req_q;
    assign pc_inc          = InstAddrBus'(pc_q + 32'd4);
    assign redirect_target = align_word(redirect_pc_i);
    assign skid_in         = '{pc: addr_q, inst: ibus_rdata_i};

    if_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .data_i   (skid_in),
        .data_o   (skid_out),
        .valid_o  (skid_valid)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= IF_IDLE;
            pc_q       <= align_word(RESET_PC);
            req_q      <= 1'b0;
            addr_q     <= ZeroWord;
            id_pc_q    <= ZeroWord;
            id_inst_q  <= NopInst;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        // Decode side takes a bubble unless something is delivered below.
        if (!stall_i) begin
            id_valid_d = 1'b0;
            id_inst_d  = NopInst;
        end

        case (state_q)
            IF_IDLE: begin
                state_d = IF_REQ;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            IF_REQ: begin
                if (ack_c) begin
                    pc_d = pc_inc;
                    if (!stall_i) begin
                        id_pc_d    = addr_q;
                        id_inst_d  = ibus_rdata_i;
                        id_valid_d = 1'b1;
                        addr_d     = pc_inc;
                    end else begin
                        skid_load = 1'b1;
                        req_d     = 1'b0;
                        state_d   = IF_HOLD;
                    end
                end
            end
            IF_HOLD: begin
                if (!stall_i && skid_valid) begin
                    id_pc_d     = skid_out.pc;
                    id_inst_d   = skid_out.inst;
                    id_valid_d  = 1'b1;
                    skid_unload = 1'b1;
                    state_d     = IF_REQ;
                    req_d       = 1'b1;
                    addr_d      = pc_q;
                end
            end
            IF_DRAIN: begin
                if (ack_c) begin
                    state_d = IF_REQ;
                    addr_d  = pc_q;
                end
            end
        endcase

        // Redirect flushes decode and the skid; a pending request must drain first.
        if (redirect_i) begin
            pc_d        = redirect_target;
            id_pc_d     = id_pc_q;
            id_inst_d   = NopInst;
            id_valid_d  = 1'b0;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            skid_clear  = 1'b1;
            req_d       = 1'b1;
            if ((state_q == IF_REQ || state_q == IF_DRAIN) && !ack_c) begin
                state_d = IF_DRAIN;
                addr_d  = addr_q;
            end else begin
                state_d = IF_REQ;
                addr_d  = redirect_target;
            end
        end
    end

    assign ibus_req_o  = req_q;
    assign ibus_addr_o = addr_q;
    assign id_pc_o     = id_pc_q;
    assign id_inst_o   = id_inst_q;
    assign id_valid_o  = id_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, streaming, stall, redirect/drain, wrap, reset abort.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    logic        ack_tie;
    logic        ack_man;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign ibus_ack_i   = ack_tie ? ibus_req_o : ack_man;
    assign ibus_rdata_i = inst_of(ibus_addr_o);

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_ack_i    (ibus_ack_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, 32'(ibus_req_o), 32'(req));
        if (req) chk({tag, ".addr"}, ibus_addr_o, addr);
    endtask

    task automatic dec(input string tag, input logic vld, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, 32'(id_valid_o), 32'(vld));
        chk({tag, ".pc"}, id_pc_o, pc);
        chk({tag, ".inst"}, id_inst_o, inst);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        ack_tie = 1'b1; ack_man = 1'b0;
        step(); step();
        chk("rst.req", 32'(ibus_req_o), 32'h0);
        chk("rst.addr", ibus_addr_o, 32'h0);
        dec("rst", 1'b0, 32'h0, 32'h0);

        // Streaming with ack tied to req
        rst = 1'b0;
        step(); bus("e1", 1'b1, 32'h0);  dec("e1", 1'b0, 32'h0, 32'h0);
        step(); bus("e2", 1'b1, 32'h4);  dec("e2", 1'b1, 32'h0, inst_of(32'h0));
        step(); bus("e3", 1'b1, 32'h8);  dec("e3", 1'b1, 32'h4, inst_of(32'h4));

        // Stall while the 0x8 ack lands
        stall_i = 1'b1;
        step(); bus("s1", 1'b0, 32'h0);  dec("s1", 1'b1, 32'h4, inst_of(32'h4));
        step(); bus("s2", 1'b0, 32'h0);  dec("s2", 1'b1, 32'h4, inst_of(32'h4));
        step(); bus("s3", 1'b0, 32'h0);  dec("s3", 1'b1, 32'h4, inst_of(32'h4));
        stall_i = 1'b0;
        step(); bus("s4", 1'b1, 32'hC);  dec("s4", 1'b1, 32'h8, inst_of(32'h8));
        step(); bus("s5", 1'b1, 32'h10); dec("s5", 1'b1, 32'hC, inst_of(32'hC));

        // Redirect with 0x10 outstanding, ack delayed
        ack_tie = 1'b0; ack_man = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step(); bus("d1", 1'b1, 32'h10); dec("d1", 1'b0, 32'hC, 32'h0);
        redirect_i = 1'b0;
        step(); bus("d2", 1'b1, 32'h10); dec("d2", 1'b0, 32'hC, 32'h0);
        step(); bus("d3", 1'b1, 32'h10); dec("d3", 1'b0, 32'hC, 32'h0);
        ack_man = 1'b1;
        step(); bus("d4", 1'b1, 32'h100); dec("d4", 1'b0, 32'hC, 32'h0);
        ack_man = 1'b0; ack_tie = 1'b1;
        step(); bus("d5", 1'b1, 32'h104); dec("d5", 1'b1, 32'h100, inst_of(32'h100));

        // Redirect coincident with ack and stall
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
        step(); bus("c1", 1'b1, 32'h200); dec("c1", 1'b0, 32'h100, 32'h0);
        stall_i = 1'b0; redirect_i = 1'b0;
        step(); bus("c2", 1'b1, 32'h204); dec("c2", 1'b1, 32'h200, inst_of(32'h200));

        // Misaligned target and PC wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        step(); bus("w1", 1'b1, 32'hFFFF_FFFC); dec("w1", 1'b0, 32'h200, 32'h0);
        redirect_i = 1'b0;
        step(); bus("w2", 1'b1, 32'h0); dec("w2", 1'b1, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC));
        step(); bus("w3", 1'b1, 32'h4); dec("w3", 1'b1, 32'h0, inst_of(32'h0));

        // Reset during a pending request, late ack afterwards
        ack_tie = 1'b0; ack_man = 1'b0;
        step(); bus("r1", 1'b1, 32'h4); dec("r1", 1'b0, 32'h0, 32'h0);
        rst = 1'b1; ack_man = 1'b1;
        step();
        chk("r2.req", 32'(ibus_req_o), 32'h0);
        chk("r2.addr", ibus_addr_o, 32'h0);
        dec("r2", 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        step(); bus("r3", 1'b1, 32'h0); dec("r3", 1'b0, 32'h0, 32'h0);
        step(); bus("r4", 1'b1, 32'h4); dec("r4", 1'b1, 32'h0, inst_of(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
